best_mv_fetch: RTL and testbench
================================

// Module: best_mv_fetch
// PURPOSE
//  Consumer end of the SAD minimum-search tree. Accepts the winning candidate index and minimum SAD
//  once per macroblock, decodes the index into a signed motion vector and emits it, then streams
//  read addresses for the best-matching BLKxBLK reference block so downstream residual/MC logic can
//  re-read it. Sits between the comparator tree output and the reference-window memory.
// PARAMETERS
//  BIT_WIDTH     14  SAD width (same as the comparator tree element width)
//  INDEX_WIDTH   8   winning-index width; candidate number = index, raster order, row-major
//  SW_LOG2       4   log2(candidates per search row); idx_x = index[SW_LOG2-1:0], idx_y = upper bits
//  MV_OFFSET     8   centre offset; mv = idx - MV_OFFSET
//  BLK           16  block edge in pixels; BLK*BLK read beats per block
//  REF_STRIDE    32  reference-window row pitch in words
//  ADDR_WIDTH    10  read address width
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    asynchronous reset, active high
//  in_valid   in   1                    index/SAD valid
//  in_ready   out  1                    block can accept (high only in IDLE)
//  in_index   in   INDEX_WIDTH          winning candidate index
//  in_sad     in   BIT_WIDTH            minimum SAD
//  mv_valid   out  1                    one-cycle pulse: mv_x/mv_y/mv_sad valid
//  mv_x       out  SW_LOG2+1            signed, idx_x - MV_OFFSET
//  mv_y       out  INDEX_WIDTH-SW_LOG2+1 signed, idx_y - MV_OFFSET
//  mv_sad     out  BIT_WIDTH            captured in_sad
//  rd_valid   out  1                    read address valid
//  rd_ready   in   1                    memory accepts address
//  rd_addr    out  ADDR_WIDTH           (idx_y+row)*REF_STRIDE + idx_x + col
//  rd_last    out  1                    high with final beat (row=col=BLK-1)
//  busy       out  1                    state != IDLE
// BEHAVIOUR
//  - Reset (async, any time incl. mid-read): state IDLE; mv_valid, rd_valid, rd_last, busy = 0;
//    mv_x, mv_y, mv_sad, rd_addr, row, col = 0; in_ready = 1 from first cycle after reset release.
//  - FSM IDLE -> DECODE -> READ -> IDLE. Handshake on in_valid&in_ready in IDLE (cycle t): capture
//    index/sad. DECODE (t+1): mv_valid=1 exactly one cycle, mv_* registered. READ from t+2.
//  - in_valid while busy is ignored (in_ready=0); no queueing.
//  - READ: row/col counters, col inner. Beat transfers on rd_valid&rd_ready; rd_addr/rd_last held
//    stable while rd_ready=0. col wraps BLK-1->0 with row++. Last transfer -> IDLE next cycle, rd_valid
//    drops; new index accepted no earlier than cycle after last beat.
//  - Address arithmetic unsigned in ADDR_WIDTH, no saturation; parameters must keep max address
//    ((2^(INDEX_WIDTH-SW_LOG2)-1+BLK-1)*REF_STRIDE + 2^SW_LOG2-1+BLK-1) < 2^ADDR_WIDTH (990 default).
//  - mv_* and mv_sad hold value until next DECODE.
// CONFIGURATION
//  MV_SKIP_EN defined: adds input skip_thresh [BIT_WIDTH] and output mv_skip [1] (valid with mv_valid,
//    reset 0). If captured sad < skip_thresh: mv_skip=1, READ bypassed, DECODE -> IDLE directly.
//  Undefined: ports absent; every accepted index runs full READ.
// TESTING
//  1 index=0x00, sad=100, rd_ready=1 -> mv_valid at t+1 with mv=(-8,-8), sad=100; addrs 0..15,32..47,
//    ..., last 495 with rd_last; 256 beats; in_ready=1 cycle after last.
//  2 index=0x88 -> mv=(0,0); first addr 264, last addr 759.
//  3 index=0xFF -> mv=(7,7); last addr 990, no wrap.
//  4 rd_ready low for beats 3-5 -> rd_addr stays 3, rd_valid held; sequence unchanged, 256 beats total.
//  5 rst asserted at beat 100 -> outputs zero immediately; in_ready=1 after release; new index restarts.
//  6 MV_SKIP_EN, skip_thresh=10: sad=5 -> mv_skip=1, no rd_valid, in_ready at t+2; sad=10 -> full read.

Source files
------------

// File: rtl/best_mv_fetch.sv
// Best motion-vector fetch: decodes the winning candidate index into a signed MV, then streams
// BLKxBLK reference-block read addresses. Optional early-skip path enabled by `define MV_SKIP_EN.
module best_mv_fetch #(
  parameter int BIT_WIDTH   = 14,
  parameter int INDEX_WIDTH = 8,
  parameter int SW_LOG2     = 4,
  parameter int MV_OFFSET   = 8,
  parameter int BLK         = 16,
  parameter int REF_STRIDE  = 32,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INDEX_WIDTH-1:0]               in_index,
  input  logic [BIT_WIDTH-1:0]                 in_sad,
  output logic                                 mv_valid,
  output logic signed [SW_LOG2:0]              mv_x,
  output logic signed [INDEX_WIDTH-SW_LOG2:0]  mv_y,
  output logic [BIT_WIDTH-1:0]                 mv_sad,
  output logic                                 rd_valid,
  input  logic                                 rd_ready,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic                                 rd_last,
  output logic                                 busy
`ifdef MV_SKIP_EN
  ,
  input  logic [BIT_WIDTH-1:0]                 skip_thresh,
  output logic                                 mv_skip
`endif
);

  localparam int XW  = SW_LOG2 + 1;
  localparam int YW  = INDEX_WIDTH - SW_LOG2 + 1;
  localparam int YIW = INDEX_WIDTH - SW_LOG2;
  localparam int CW  = (BLK > 1) ? $clog2(BLK) : 1;

  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(REF_STRIDE);
  // Jump from the last column of one row to the first column of the next.
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(REF_STRIDE - (BLK - 1));
  localparam logic [CW-1:0]         LAST    = CW'(BLK - 1);

  typedef enum logic [1:0] {IDLE, DECODE, READ} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       row, col;
  logic [SW_LOG2-1:0]  idx_x;
  logic [YIW-1:0]      idx_y;
  logic                accept, beat;

  assign idx_x    = in_index[SW_LOG2-1:0];
  assign idx_y    = in_index[INDEX_WIDTH-1:SW_LOG2];

  assign in_ready = (state == IDLE);
  assign mv_valid = (state == DECODE);
  assign rd_valid = (state == READ);
  assign busy     = (state != IDLE);
  assign rd_last  = rd_valid && (row == LAST) && (col == LAST);
  assign accept   = in_valid & in_ready;
  assign beat     = rd_valid & rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = DECODE;
`ifdef MV_SKIP_EN
      DECODE: state_nxt = mv_skip ? IDLE : READ;
`else
      DECODE: state_nxt = READ;
`endif
      READ:   if (beat && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on handshake so mv_* are already registered while mv_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_x    <= '0;
      mv_y    <= '0;
      mv_sad  <= '0;
      rd_addr <= '0;
      row     <= '0;
      col     <= '0;
    end else if (accept) begin
      mv_x    <= $signed({1'b0, idx_x}) - $signed(XW'(MV_OFFSET));
      mv_y    <= $signed({1'b0, idx_y}) - $signed(YW'(MV_OFFSET));
      mv_sad  <= in_sad;
      rd_addr <= ADDR_WIDTH'(idx_y) * STRIDE_A + ADDR_WIDTH'(idx_x);
      row     <= '0;
      col     <= '0;
    end else if (beat) begin
      if (col == LAST) begin
        col     <= '0;
        row     <= rd_last ? '0 : row + CW'(1);
        rd_addr <= rd_addr + ROW_STEP;
      end else begin
        col     <= col + CW'(1);
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef MV_SKIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mv_skip <= 1'b0;
    else if (accept) mv_skip <= (in_sad < skip_thresh);
  end
`endif

endmodule

// File: tb/tb_best_mv_fetch.sv
// Scoreboard bench for best_mv_fetch: expected MVs and read addresses are queued at stimulus
// time and popped by negedge monitors as the DUT presents them.
module tb_best_mv_fetch;
  localparam int BLK = 16;
  localparam int NB  = BLK * BLK;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_index;
  logic [13:0] in_sad;
  logic        mv_valid;
  logic signed [4:0] mv_x;
  logic signed [4:0] mv_y;
  logic [13:0] mv_sad;
  logic        rd_valid;
  logic        rd_ready;
  logic [9:0]  rd_addr;
  logic        rd_last;
  logic        busy;
`ifdef MV_SKIP_EN
  logic [13:0] skip_thresh;
  logic        mv_skip;
`endif

  typedef struct {int x; int y; int sad; bit skip;} mv_e_t;
  typedef struct {int addr; bit last;} rd_e_t;

  mv_e_t mv_q[$];
  rd_e_t rd_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  best_mv_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_sad(in_sad),
    .mv_valid(mv_valid), .mv_x(mv_x), .mv_y(mv_y), .mv_sad(mv_sad),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_last(rd_last),
    .busy(busy)
`ifdef MV_SKIP_EN
    , .skip_thresh(skip_thresh), .mv_skip(mv_skip)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    mv_e_t m;
    rd_e_t r;
    int gx, gy;
    if (mv_valid) begin
      if (mv_q.size() == 0) chk("mv_q_empty", 1, 0);
      else begin
        m  = mv_q.pop_front();
        gx = mv_x;
        gy = mv_y;
        chk("mv_x", gx, m.x);
        chk("mv_y", gy, m.y);
        chk("mv_sad", 32'(mv_sad), m.sad);
`ifdef MV_SKIP_EN
        chk("mv_skip", 32'(mv_skip), 32'(m.skip));
`endif
      end
    end
    if (rd_valid && rd_ready) begin
      if (rd_q.size() == 0) chk("rd_q_empty", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_addr", 32'(rd_addr), r.addr);
        chk("rd_last", 32'(rd_last), 32'(r.last));
      end
    end
  end

  task automatic run_mb(input int idx, input int sad, input int stall_at, input int abort_at,
                        input bit junk, input bit skip);
    int ix, iy, beats, stall, cyc, exp_stall;
    mv_e_t m;
    rd_e_t r;
    ix = idx & 15;
    iy = idx >> 4;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("in_ready_wait", 32'(in_ready), 1);
    m.x = ix - 8; m.y = iy - 8; m.sad = sad; m.skip = skip;
    mv_q.push_back(m);
    if (!skip)
      for (int rr = 0; rr < BLK; rr++)
        for (int cc = 0; cc < BLK; cc++) begin
          r.addr = (iy + rr) * 32 + ix + cc;
          r.last = (rr == BLK - 1) && (cc == BLK - 1);
          rd_q.push_back(r);
        end
    in_valid = 1'b1; in_index = 8'(idx); in_sad = 14'(sad);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mv_valid_t1", 32'(mv_valid), 1);
    chk("in_ready_t1", 32'(in_ready), 0);
    chk("busy_t1", 32'(busy), 1);
    @(posedge clk); #1;
    if (skip) begin
      chk("skip_rd_valid", 32'(rd_valid), 0);
      chk("skip_in_ready", 32'(in_ready), 1);
      return;
    end
    chk("rd_valid_t2", 32'(rd_valid), 1);
    exp_stall = (iy + stall_at / BLK) * 32 + ix + stall_at % BLK;
    beats = 0; stall = 0; cyc = 0;
    while (beats < NB && cyc < 4000) begin
      if (beats == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_mv_x", 32'(mv_x), 0);
        chk("rst_rd_last", 32'(rd_last), 0);
        rd_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        chk("rel_busy", 32'(busy), 0);
        return;
      end
      if (junk) begin
        in_valid = (beats < 250);
        in_index = 8'h33;
      end
      if (beats == stall_at && stall < 3) begin
        rd_ready = 1'b0;
        stall++;
        chk("stall_rd_valid", 32'(rd_valid), 1);
        chk("stall_rd_addr", 32'(rd_addr), exp_stall);
      end else rd_ready = 1'b1;
      if (rd_valid && rd_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    rd_ready = 1'b1;
    chk("beats", beats, NB);
    chk("in_ready_after_last", 32'(in_ready), 1);
    chk("rd_valid_after_last", 32'(rd_valid), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_index = '0; in_sad = '0; rd_ready = 1'b1;
`ifdef MV_SKIP_EN
    skip_thresh = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mv_valid", 32'(mv_valid), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rd_last", 32'(rd_last), 0);
    chk("reset_rd_addr", 32'(rd_addr), 0);
    chk("reset_mv_sad", 32'(mv_sad), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 1);

    run_mb(8'h00, 100, -1, -1, 1'b0, 1'b0);
    run_mb(8'h88, 200, -1, -1, 1'b1, 1'b0);
    run_mb(8'hFF, 16383, -1, -1, 1'b0, 1'b0);
    run_mb(8'h25, 7, 3, -1, 1'b0, 1'b0);
    run_mb(8'h4A, 55, -1, 100, 1'b0, 1'b0);
    run_mb(8'h13, 300, -1, -1, 1'b0, 1'b0);
`ifdef MV_SKIP_EN
    skip_thresh = 14'd10;
    run_mb(8'h21, 5, -1, -1, 1'b0, 1'b1);
    run_mb(8'h21, 10, -1, -1, 1'b0, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("mv_q_drained", mv_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
